// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
//   arb_state_t : arbiter FSM state (IDLE = nobody owns the UART, OWN = a requester owns it)
//   rr_next     : modulo-n increment used to advance the round-robin pointer
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    function automatic int rr_next(input int ptr, input int n);
        if (ptr + 1 >= n) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between NUM_REQ requesters, the arbiter and the UART TX.
//   req_valid/req_data/req_last : requester i offers byte req_data[8*i +: 8]
//   req_ack                     : one-cycle pulse, requester i's byte was consumed
//   tx_data/tx_data_valid       : byte offered to the UART
//   tx_data_ack                 : UART took tx_data this cycle (single-cycle pulse)
//   master : arbiter view, slave : requester/UART environment view
//
// Handshake: a byte transfers on the cycle where its valid and the matching
// ack are both high. Once valid is raised, data and last stay stable until
// that cycle; an ack seen while valid is low carries no meaning and is ignored.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ack;
    logic [7:0]           tx_data;
    logic                 tx_data_valid;
    logic                 tx_data_ack;

    modport master (
        input  req_valid, req_data, req_last, tx_data_ack,
        output req_ack, tx_data, tx_data_valid
    );

    modport slave (
        output req_valid, req_data, req_last, tx_data_ack,
        input  req_ack, tx_data, tx_data_valid
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : highest-priority index for this pick
//   onehot : one-hot of the chosen request (0 when none)
//   idx    : index of the chosen request (0 when none)
//   any    : at least one request is set
// The scan starts at ptr and wraps, so the first set bit at or cyclically
// after ptr wins.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    int cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!any && req[IDX_W'(cand)]) begin
                any                   = 1'b1;
                idx                   = IDX_W'(cand);
                onehot[IDX_W'(cand)]  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Round-robin arbitration at packet granularity: a granted requester keeps the
// UART until one of its bytes flagged last is accepted. A gap watchdog takes
// the UART back from an owner that stops offering bytes mid-packet.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : requester and UART byte handshakes (master modport)
//   grant_id    : current / last owner index
//   busy        : a requester owns the UART
//   abort_pulse : one-cycle pulse when the watchdog revokes a grant
//   dbg_state   : arbiter FSM state
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_GAP = 1024,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus,
    output logic [ID_W-1:0]   grant_id,
    output logic              busy,
    output logic              abort_pulse,
    output arb_state_t        dbg_state
);
    // Watchdog off still needs a legal 1-bit counter; it simply never moves.
    localparam bit                WD_EN     = (MAX_GAP > 0);
    localparam int                GAP_W     = WD_EN ? $clog2(MAX_GAP + 1) : 1;
    localparam logic [GAP_W-1:0]  GAP_LIMIT = WD_EN ? GAP_W'(MAX_GAP - 1) : '0;
    localparam logic [GAP_W-1:0]  GAP_SAT   = '1;

    arb_state_t           state_q, state_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]   grant_oh_q, grant_oh_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 busy_q, busy_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_any;

    logic                 owner_valid;
    logic                 owner_last;
    logic                 tx_valid;
    logic [7:0]           tx_byte;
    logic                 accept;
    logic                 expire;
    logic [NUM_REQ-1:0]   ack_vec;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req    (bus.req_valid),
        .ptr    (rr_ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        // The UART path is a mux on the registered owner, so an accepted byte
        // always belongs to the requester that was granted a cycle earlier.
        owner_valid = bus.req_valid[grant_id_q];
        owner_last  = bus.req_last[grant_id_q];
        tx_valid    = (state_q == OWN) && owner_valid;
        tx_byte     = tx_valid ? bus.req_data[{grant_id_q, 3'b000} +: 8] : 8'h00;
        accept      = tx_valid && bus.tx_data_ack;
        // Expiry needs valid low, so it can never collide with a last-byte accept.
        expire      = WD_EN && (state_q == OWN) && !owner_valid && (gap_cnt_q == GAP_LIMIT);
        ack_vec     = accept ? grant_oh_q : '0;

        state_d    = state_q;
        grant_id_d = grant_id_q;
        grant_oh_d = grant_oh_q;
        rr_ptr_d   = rr_ptr_q;
        busy_d     = busy_q;
        gap_cnt_d  = gap_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = OWN;
                    grant_id_d = pick_idx;
                    grant_oh_d = pick_oh;
                    busy_d     = 1'b1;
                    gap_cnt_d  = '0;
                end
            end
            OWN: begin
                if ((accept && owner_last) || expire) begin
                    state_d   = IDLE;
                    rr_ptr_d  = ID_W'(rr_next(int'(grant_id_q), NUM_REQ));
                    busy_d    = 1'b0;
                    gap_cnt_d = '0;
                end else if (owner_valid) begin
                    gap_cnt_d = '0;
                end else if (WD_EN && (gap_cnt_q != GAP_SAT)) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            grant_oh_q <= '0;
            rr_ptr_q   <= '0;
            busy_q     <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            grant_oh_q <= grant_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= busy_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign bus.tx_data       = tx_byte;
    assign bus.tx_data_valid = tx_valid;
    assign bus.req_ack       = ack_vec;
    assign grant_id          = grant_id_q;
    assign busy              = busy_q;
    assign abort_pulse       = expire;
    assign dbg_state         = state_q;
endmodule
